// File: rtl/bsg_tag_serial_tx.sv
// Bit-serial transmitter for the bsg_tag link: emits the master-reset preamble after
// reset, then serialises {start, len, data_not_reset, nodeid, payload} LSB first.
module bsg_tag_serial_tx #(
    parameter  int tag_els_p               = 16,
    parameter  int tag_max_payload_width_p = 8,
    parameter  int reset_ones_p            = 32,
    parameter  int reset_zeros_p           = 8,
    parameter  int gap_p                   = 1,
    localparam int lg_els_lp = (tag_els_p > 1) ? $clog2(tag_els_p) : 1,
    localparam int lg_w_lp   = (tag_max_payload_width_p + 1 > 1)
                               ? $clog2(tag_max_payload_width_p + 1) : 1
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               v_i,
    output logic                               ready_and_o,
    input  logic [lg_els_lp-1:0]               nodeid_i,
    input  logic                               data_not_reset_i,
    input  logic [lg_w_lp-1:0]                 len_i,
    input  logic [tag_max_payload_width_p-1:0] payload_i,
    output logic                               tag_data_o,
    output logic                               tag_en_o,
    output logic                               init_done_o
);

    localparam int hdr_lp       = 1 + lg_w_lp + 1 + lg_els_lp;
    localparam int body_w_lp    = lg_w_lp + 1 + lg_els_lp + tag_max_payload_width_p;
    localparam int frame_max_lp = hdr_lp + tag_max_payload_width_p;
    localparam int max_a_lp     = (frame_max_lp > reset_ones_p) ? frame_max_lp : reset_ones_p;
    localparam int max_b_lp     = (reset_zeros_p > gap_p) ? reset_zeros_p : gap_p;
    localparam int cnt_max_lp   = (max_a_lp > max_b_lp) ? max_a_lp : max_b_lp;
    localparam int cnt_w_lp     = $clog2(cnt_max_lp + 1);

    // State names the bit currently on tag_data_o; cnt_q counts bits already emitted in it.
    typedef enum logic [2:0] {
        S_INIT_ONES,
        S_INIT_ZEROS,
        S_IDLE,
        S_SEND,
        S_GAP
    } state_e;

    state_e                 state_q, state_d;
    logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
    logic [cnt_w_lp-1:0]    frame_len_q, frame_len_d;
    logic [body_w_lp-1:0]   frame_q, frame_d;
    logic                   data_q, data_d;
    logic                   en_q, en_d;
    logic                   init_done_q, init_done_d;
    logic [lg_w_lp-1:0]     len_clamped;

    assign len_clamped = (len_i > lg_w_lp'(tag_max_payload_width_p))
                       ? lg_w_lp'(tag_max_payload_width_p) : len_i;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        frame_len_d = frame_len_q;
        data_d      = 1'b0;
        en_d        = 1'b1;
        init_done_d = init_done_q;

        case (state_q)
            S_INIT_ONES: begin
                if (cnt_q == cnt_w_lp'(reset_ones_p)) begin
                    state_d = S_INIT_ZEROS;
                    cnt_d   = cnt_w_lp'(1);
                end else begin
                    data_d = 1'b1;
                    cnt_d  = cnt_q + cnt_w_lp'(1);
                end
            end
            S_INIT_ZEROS: begin
                if (cnt_q == cnt_w_lp'(reset_zeros_p)) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + cnt_w_lp'(1);
                end
            end
            S_IDLE: begin
                if (v_i) begin
                    state_d     = S_SEND;
                    cnt_d       = cnt_w_lp'(1);
                    data_d      = 1'b1;
                    frame_d     = {payload_i, nodeid_i, data_not_reset_i, len_clamped};
                    frame_len_d = cnt_w_lp'(hdr_lp) + cnt_w_lp'(len_clamped);
                end
            end
            S_SEND: begin
                if (cnt_q == frame_len_q) begin
                    // The idle cycle itself supplies the final gap zero, so back-to-back
                    // frames are separated by exactly gap_p zeros.
                    if (gap_p > 1) begin
                        state_d = S_GAP;
                        cnt_d   = cnt_w_lp'(1);
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    data_d  = frame_q[0];
                    frame_d = frame_q >> 1;
                    cnt_d   = cnt_q + cnt_w_lp'(1);
                end
            end
            S_GAP: begin
                if (cnt_q >= cnt_w_lp'(gap_p - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_w_lp'(1);
                end
            end
            default: begin
                state_d = S_INIT_ONES;
                cnt_d   = '0;
                en_d    = 1'b0;
            end
        endcase
    end

    // NOTE: the frame shift register is reset along with the control state even though it is
    // reloaded before use; it is small and this keeps every output-visible bit deterministic.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_INIT_ONES;
            cnt_q       <= '0;
            frame_len_q <= '0;
            frame_q     <= '0;
            data_q      <= 1'b0;
            en_q        <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_len_q <= frame_len_d;
            frame_q     <= frame_d;
            data_q      <= data_d;
            en_q        <= en_d;
            init_done_q <= init_done_d;
        end
    end

    assign ready_and_o = (state_q == S_IDLE);
    assign tag_data_o  = data_q;
    assign tag_en_o    = en_q;
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_bsg_tag_serial_tx.sv
// Self-checking bench for bsg_tag_serial_tx: table of packets with hand-derived serial
// frames, a bit-level scoreboard queue, and reset/back-to-back corner sequences.
module tb_bsg_tag_serial_tx;

    typedef struct {
        logic [3:0]  nodeid;
        logic        dnr;
        logic [3:0]  len;
        logic [7:0]  payload;
        int          n;
        logic [17:0] frame;   // bit n-1 is transmitted first
    } pkt_t;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       v_i;
    logic       ready_and_o;
    logic [3:0] nodeid_i;
    logic       data_not_reset_i;
    logic [3:0] len_i;
    logic [7:0] payload_i;
    logic       tag_data_o;
    logic       tag_en_o;
    logic       init_done_o;

    bsg_tag_serial_tx dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .v_i              (v_i),
        .ready_and_o      (ready_and_o),
        .nodeid_i         (nodeid_i),
        .data_not_reset_i (data_not_reset_i),
        .len_i            (len_i),
        .payload_i        (payload_i),
        .tag_data_o       (tag_data_o),
        .tag_en_o         (tag_en_o),
        .init_done_o      (init_done_o)
    );

    always #5 clk = ~clk;

    pkt_t tbl [5];
    logic exp_q [$];
    logic exp_rdy;
    logic init_m;
    int   cur_idx;
    int   stop_idx;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive_entry();
        nodeid_i         = tbl[cur_idx].nodeid;
        data_not_reset_i = tbl[cur_idx].dnr;
        len_i            = tbl[cur_idx].len;
        payload_i        = tbl[cur_idx].payload;
    endtask

    task automatic push_preamble();
        repeat (32) exp_q.push_back(1'b1);
        repeat (8)  exp_q.push_back(1'b0);
    endtask

    // One clock: detect handshake from the model's ready, then compare the new cycle.
    task automatic step();
        logic hs;
        logic exp_d;
        hs = v_i && exp_rdy;
        @(posedge clk);
        #1;
        if (hs) begin
            for (int i = tbl[cur_idx].n - 1; i >= 0; i--) exp_q.push_back(tbl[cur_idx].frame[i]);
            cur_idx++;
            if (cur_idx >= stop_idx) v_i = 1'b0;
            else drive_entry();
        end
        if (exp_q.size() == 0) begin
            exp_d   = 1'b0;
            exp_rdy = 1'b1;
            init_m  = 1'b1;
        end else begin
            exp_d   = exp_q.pop_front();
            exp_rdy = 1'b0;
        end
        check("tag_data", 32'(tag_data_o), 32'(exp_d));
        check("tag_en", 32'(tag_en_o), 32'd1);
        check("ready", 32'(ready_and_o), 32'(exp_rdy));
        check("init_done", 32'(init_done_o), 32'(init_m));
    endtask

    // Send table entries [first, last) with v_i held, then run until the stream is idle.
    task automatic send_range(input int first, input int last, input int budget);
        int n;
        n        = 0;
        cur_idx  = first;
        stop_idx = last;
        drive_entry();
        v_i = 1'b1;
        while ((v_i || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_within_budget", 32'(n < budget), 32'd1);
        v_i = 1'b0;
        repeat (2) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tag_data"}, 32'(tag_data_o), 32'd0);
        check({tag, "_tag_en"}, 32'(tag_en_o), 32'd0);
        check({tag, "_ready"}, 32'(ready_and_o), 32'd0);
        check({tag, "_init_done"}, 32'(init_done_o), 32'd0);
    endtask

    initial begin
        tbl[0] = '{4'd5,  1'b1, 4'd8,  8'hA5, 18, 18'b100011101010100101};
        tbl[1] = '{4'd3,  1'b0, 4'd0,  8'h3C, 10, 18'b00000000_1000001100};
        tbl[2] = '{4'd0,  1'b1, 4'd15, 8'hFF, 18, 18'b100011000011111111};
        tbl[3] = '{4'd15, 1'b1, 4'd3,  8'h06, 13, 18'b00000_1110011111011};
        tbl[4] = '{4'd10, 1'b0, 4'd1,  8'hFE, 11, 18'b0000000_11000001010};

        reset_i = 1'b1;
        v_i     = 1'b0;
        cur_idx = 0;
        stop_idx = 0;
        drive_entry();
        exp_rdy = 1'b0;
        init_m  = 1'b0;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");

        // Preamble with v_i already high: the request must wait for IDLE, then three
        // packets stream back-to-back separated by single gap zeros.
        reset_i = 1'b0;
        push_preamble();
        send_range(0, 3, 300);

        // Isolated packets with idle cycles in between.
        send_range(3, 4, 100);
        repeat (3) step();
        send_range(4, 5, 100);

        // Abort mid-payload with an asynchronous reset between clock edges.
        cur_idx  = 0;
        stop_idx = 1;
        drive_entry();
        v_i = 1'b1;
        repeat (13) step();
        v_i = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_mid_frame_held");
        exp_q.delete();
        exp_rdy = 1'b0;
        init_m  = 1'b0;
        reset_i = 1'b0;
        push_preamble();
        send_range(1, 2, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
